// File: rtl/fir_pkg.sv
// Shared helpers for the CLA moving-sum FIR: default sizes, tree-depth and
// tree-packing arithmetic, and operand sign extension.
package fir_pkg;

    localparam int unsigned DEF_W    = 16;
    localparam int unsigned DEF_TAPS = 8;

    typedef logic signed [DEF_W-1:0] sample_t;

    function automatic int unsigned lg_of(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

    // Bit offset of tree level k inside the flat tree register; levels 1..k-1
    // precede it, level j holding taps>>j words of w+j bits.
    function automatic int unsigned lvl_off(input int unsigned w, input int unsigned taps,
                                            input int unsigned k);
        int unsigned off;
        off = 0;
        for (int unsigned j = 1; j < k; j++) begin
            off = off + (taps >> j) * (w + j);
        end
        return off;
    endfunction

    function automatic logic [63:0] sext(input logic [63:0] x, input int unsigned w);
        logic [63:0] m;
        m = ~64'd0 << w;
        return x[w-1] ? (x | m) : (x & ~m);
    endfunction

endpackage

// File: rtl/cla_add.sv
// Combinational N-bit signed carry-lookahead adder with an exact N+1-bit sum.
module cla_add
    import fir_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N:0]   o_sum
);

    localparam int unsigned M = N + 1;

    logic [M-1:0] w_a;
    logic [M-1:0] w_b;
    logic [M-1:0] w_p;
    logic [M-2:0] w_g;
    logic [M-1:0] w_c;
    logic         w_term;

    assign w_a = M'(sext(64'(i_a), N));
    assign w_b = M'(sext(64'(i_b), N));
    assign w_p = w_a ^ w_b;
    assign w_g = w_a[M-2:0] & w_b[M-2:0];

    // Each carry is the flat OR of every generate propagated up to its bit.
    always_comb begin
        w_c    = '0;
        w_term = 1'b0;
        for (int i = 1; i < M; i++) begin
            for (int j = 0; j < i; j++) begin
                w_term = w_g[j];
                for (int k = j + 1; k < i; k++) begin
                    w_term = w_term & w_p[k];
                end
                w_c[i] = w_c[i] | w_term;
            end
        end
    end

    assign o_sum = w_p ^ w_c;

endmodule

// File: rtl/fir_ntap_cla_pipe.sv
// N-tap unity-coefficient FIR: valid-qualified delay line feeding a registered
// binary tree of CLA adders, with optional rounded-average output.
module fir_ntap_cla_pipe
    import fir_pkg::*;
#(
    parameter int unsigned W    = DEF_W,
    parameter int unsigned TAPS = DEF_TAPS,
    localparam int unsigned LG  = lg_of(TAPS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   in_valid,
    input  logic signed [W-1:0]    a_in,
    input  logic                   avg_mode,
    output logic                   out_valid,
    output logic signed [W+LG-1:0] s_out
);

    localparam int unsigned SW      = W + LG;
    localparam int unsigned TREE_W  = lvl_off(W, TAPS, LG + 1);
    localparam int unsigned SUM_OFF = lvl_off(W, TAPS, LG);
    localparam logic [SW-1:0] RND   = SW'(1) << (LG - 1);

    logic [W-1:0]      r_tap [TAPS];
    logic [TREE_W-1:0] r_tree;
    logic [TREE_W-1:0] w_tree_d;
    logic [LG:0]       r_vld;
    logic [LG:0]       r_mode;
    logic              r_out_valid;
    logic [SW-1:0]     r_s_out;
    logic [SW-1:0]     w_sum;
    logic [SW:0]       w_rnd;
    logic [SW-1:0]     w_avg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) r_tap[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < TAPS; i++) r_tap[i] <= '0;
        end else if (in_valid) begin
            r_tap[0] <= a_in;
            for (int i = 1; i < TAPS; i++) r_tap[i] <= r_tap[i-1];
        end
    end

    // Level k packs TAPS>>k words of W+k bits; level 1 reads the taps directly.
    for (genvar k = 1; k <= LG; k++) begin : g_lvl
        localparam int unsigned NW   = W + k;
        localparam int unsigned NS   = TAPS >> k;
        localparam int unsigned OFF  = lvl_off(W, TAPS, k);
        localparam int unsigned POFF = lvl_off(W, TAPS, k - 1);

        for (genvar i = 0; i < NS; i++) begin : g_node
            logic [NW-2:0] w_a;
            logic [NW-2:0] w_b;

            if (k == 1) begin : g_src_tap
                assign w_a = r_tap[2*i];
                assign w_b = r_tap[2*i+1];
            end else begin : g_src_lvl
                assign w_a = r_tree[POFF + (2*i)*(NW-1) +: NW-1];
                assign w_b = r_tree[POFF + (2*i+1)*(NW-1) +: NW-1];
            end

            cla_add #(
                .N (NW - 1)
            ) u_add (
                .i_a   (w_a),
                .i_b   (w_b),
                .o_sum (w_tree_d[OFF + i*NW +: NW])
            );
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tree <= '0;
            r_vld  <= '0;
            r_mode <= '0;
        end else begin
            r_tree <= clear ? '0 : w_tree_d;
            r_vld  <= clear ? '0 : {r_vld[LG-1:0], in_valid};
            r_mode <= {r_mode[LG-1:0], avg_mode};
        end
    end

    assign w_sum = r_tree[SUM_OFF +: SW];

    cla_add #(
        .N (SW)
    ) u_rnd (
        .i_a   (w_sum),
        .i_b   (RND),
        .o_sum (w_rnd)
    );

    assign w_avg = SW'($signed(w_rnd) >>> LG);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_s_out     <= '0;
        end else begin
            r_out_valid <= r_vld[LG] & ~clear;
            if (r_vld[LG] && !clear) begin
                r_s_out <= r_mode[LG] ? w_avg : w_sum;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign s_out     = r_s_out;

endmodule

// File: tb/tb_fir_ntap_cla_pipe.sv
// Bench for fir_ntap_cla_pipe: directed and random stimulus against a
// window-sum reference model; a second small instance covers W=8, TAPS=4.
module tb_fir_ntap_cla_pipe;

    localparam int W     = 16;
    localparam int TAPS  = 8;
    localparam int LG    = 3;
    localparam int W2    = 8;
    localparam int TAPS2 = 4;
    localparam int LG2   = 2;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   clear = 1'b0;
    logic                   in_valid = 1'b0;
    logic signed [W-1:0]    a_in = '0;
    logic                   avg_mode = 1'b0;
    logic                   out_valid;
    logic signed [W+LG-1:0] s_out;

    logic                     in_valid2 = 1'b0;
    logic signed [W2-1:0]     a_in2 = '0;
    logic                     avg_mode2 = 1'b0;
    logic                     out_valid2;
    logic signed [W2+LG2-1:0] s_out2;

    fir_ntap_cla_pipe #(
        .W    (W),
        .TAPS (TAPS)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .a_in      (a_in),
        .avg_mode  (avg_mode),
        .out_valid (out_valid),
        .s_out     (s_out)
    );

    fir_ntap_cla_pipe #(
        .W    (W2),
        .TAPS (TAPS2)
    ) u_dut2 (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid2),
        .a_in      (a_in2),
        .avg_mode  (avg_mode2),
        .out_valid (out_valid2),
        .s_out     (s_out2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int val;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   win [TAPS];
    res_t pend [$];
    int   exp_s = 0;
    bit   exp_v = 1'b0;

    task automatic chk(input string tag, input logic signed [31:0] got, input int expv);
        checks++;
        assert (got === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < TAPS; i++) win[i] = 0;
        pend.delete();
    endfunction

    // One clock of DUT1: drive at negedge, advance the model at posedge, check after.
    task automatic tick(input bit v, input int a, input bit m, input bit c, input string tag);
        int s;
        @(negedge clk);
        in_valid = v;
        a_in     = a[W-1:0];
        avg_mode = m;
        clear    = c;
        @(posedge clk);
        cyc++;
        exp_v = 1'b0;
        if (c) begin
            model_clear();
        end else begin
            if (pend.size() > 0 && pend[0].due == cyc) begin
                exp_v = 1'b1;
                exp_s = pend[0].val;
                void'(pend.pop_front());
            end
            if (v) begin
                for (int i = TAPS - 1; i > 0; i--) win[i] = win[i-1];
                win[0] = a;
                s = 0;
                for (int i = 0; i < TAPS; i++) s += win[i];
                pend.push_back('{due: cyc + LG + 1, val: m ? ((s + (1 << (LG - 1))) >>> LG) : s});
            end
        end
        #1;
        chk({tag, "/out_valid"}, out_valid, int'(exp_v));
        chk({tag, "/s_out"}, s_out, exp_s);
    endtask

    task automatic tick2(input bit v, input int a, input bit m, input string tag);
        in_valid2 = v;
        a_in2     = a[W2-1:0];
        avg_mode2 = m;
        tick(0, 0, 0, 0, tag);
    endtask

    task automatic flush(input int n, input string tag);
        repeat (n) tick(0, 0, 0, 0, tag);
    endtask

    // Async reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset(input string tag);
        in_valid  = 1'b0;
        clear     = 1'b0;
        in_valid2 = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        model_clear();
        exp_s = 0;
        exp_v = 1'b0;
        chk({tag, "/out_valid"}, out_valid, 0);
        chk({tag, "/s_out"}, s_out, 0);
        chk({tag, "/out_valid2"}, out_valid2, 0);
        chk({tag, "/s_out2"}, s_out2, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        model_clear();
        #12;
        chk("reset/out_valid", out_valid, 0);
        chk("reset/s_out", s_out, 0);
        chk("reset/out_valid2", out_valid2, 0);
        chk("reset/s_out2", s_out2, 0);
        @(negedge clk);
        reset = 1'b0;

        // Impulse
        tick(1, 100, 0, 0, "impulse");
        repeat (12) tick(1, 0, 0, 0, "impulse");

        // Extremes
        repeat (8) tick(1, 32767, 0, 0, "max");
        flush(4, "max");
        chk("max/final", s_out, 262136);
        repeat (8) tick(1, -32768, 0, 0, "min");
        flush(4, "min");
        chk("min/final", s_out, -262144);

        // Average rounding
        tick(0, 0, 0, 1, "avg");
        repeat (4) tick(1, 1, 1, 0, "avg_pos");
        flush(4, "avg_pos");
        chk("avg_pos/final", s_out, 1);
        tick(0, 0, 0, 1, "avg");
        tick(1, 0, 1, 0, "avg_neg");
        repeat (7) tick(1, -1, 1, 0, "avg_neg");
        flush(4, "avg_neg");
        chk("avg_neg/final", s_out, -1);

        // Gapped valid
        tick(0, 0, 0, 1, "gap");
        for (int i = 1; i <= 8; i++) begin
            tick(1, i, 0, 0, "gap");
            tick(0, 99, 0, 0, "gap");
        end
        flush(4, "gap");
        chk("gap/final", s_out, 36);

        // Clear colliding with a valid sample
        repeat (3) tick(1, 1000, 0, 0, "clr");
        tick(1, 77, 0, 1, "clr_edge");
        tick(1, 5, 0, 0, "clr_after");
        flush(4, "clr_after");
        chk("clr/final", s_out, 5);

        // Random stream with an async reset in the middle
        for (int i = 0; i < 300; i++) begin
            if (i == 150) do_reset("rand_reset");
            tick($urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)) - 32768,
                 1'($urandom_range(0, 1)), $urandom_range(0, 40) == 0, "rand");
        end
        flush(6, "rand_flush");

        // Narrow variant
        repeat (4) tick2(1, 127, 0, "narrow_max");
        in_valid2 = 1'b0;
        flush(4, "narrow");
        chk("narrow_max/final", s_out2, 127 * 4);
        repeat (4) tick2(1, -128, 0, "narrow_min");
        in_valid2 = 1'b0;
        flush(4, "narrow");
        chk("narrow_min/final", s_out2, -128 * 4);
        repeat (4) tick2(1, 127, 1, "narrow_avg");
        in_valid2 = 1'b0;
        flush(4, "narrow");
        chk("narrow_avg/final", s_out2, (127 * 4 + 2) >>> 2);
        repeat (2) tick2(1, 100, 0, "narrow_mid");
        do_reset("narrow_reset");
        flush(5, "post_reset");
        chk("post_reset/out_valid2", out_valid2, 0);
        chk("post_reset/s_out2", s_out2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
